eu_exec_unit: RTL and testbench
===============================

Name: eu_exec_unit

Overview:
- Parametrised successor to the EU register/ALU execute stage.
- Accepts decoded 8086-style instruction words plus an optional immediate through a valid/ready port, and buffers them in an internal queue.
- Executes each entry serially: read the register file, run the ALU, update flags, write back, then present the result on a valid/ready output port.
- Sits between the BIU instruction queue and the EU control logic.

Parameters:
- DATA_W, 16, register/ALU width in bits; must be ≥ 8.
- NUM_REGS, 8, general registers; the r/m and reg fields address indices 0..NUM_REGS-1.
- QUEUE_DEPTH, 4, input queue entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction entry offered.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  16  [15:10] opcode, [9] d, [8] w, [7:6] mod, [5:3] reg, [2:0] r/m.
- in_has_imm  in  1  entry carries an immediate.
- in_imm  in  DATA_W  immediate value.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  ALU result, full width.
- out_wb  out  1  1 = result was written to a register.
- out_illegal  out  1  unsupported opcode or mod.
- status  out  16  flags: CF bit0, PF bit2, ZF bit6, SF bit7, OF bit11; all other bits 0.
- dbg_sel  in  $clog2(NUM_REGS)  debug read index.
- dbg_data  out  DATA_W  combinational read of register dbg_sel.

Behaviour:
- Reset (async, reset_n = 0):
  - queue emptied; FSM to IDLE; all registers 0.
  - status, out_valid, out_result, out_wb and out_illegal all 0.
  - in_ready returns 1 on the first edge after release.
  - Reset mid-operation discards all in-flight and queued work and suppresses any pending writeback.
- Queue: an entry is pushed when in_valid && in_ready. When full, in_ready = 0 even if a pop occurs in the same cycle. Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE → READ: queue non-empty; pop the head.
  - READ → EXEC: latch src/dst operands.
  - EXEC → WB: compute, register the result and flags, write the destination register, raise out_valid.
  - WB: hold while out_valid && !out_ready. On handshake go to READ if the queue is non-empty (popping the head), else to IDLE.
- Latency and throughput:
  - Entry accepted at edge E0 into an empty, idle unit → out_valid high after E3.
  - Register write lands at E3.
  - With out_ready = 1 held, throughput is 1 result per 3 cycles.
  - Outputs remain stable while stalled.
- Operand selection:
  - mod = 11: d = 1 → dst = reg, src = r/m; d = 0 → dst = r/m, src = reg.
  - mod = 00 with in_has_imm = 1: dst = r/m, src = in_imm.
  - Any other mod, or mod = 00 without an immediate → out_illegal = 1, no write, status unchanged.
- Opcodes:
  - 000000 ADD, 000010 OR, 001000 AND, 001010 SUB, 001100 XOR: write dst, update flags.
  - 001110 CMP: SUB without write; flags updated; out_wb = 0.
  - 100010 MOV: write src to dst; flags unchanged.
  - Any other opcode: illegal.
- Width (w bit):
  - w = 1: DATA_W-bit operation.
  - w = 0: low byte only. Writeback preserves dst[DATA_W-1:8]; out_result upper bits are 0. CF/OF/SF are taken at bit 7.
- Flags:
  - CF = carry-out (ADD) or borrow (SUB/CMP).
  - OF = signed overflow.
  - ZF = result == 0 (within the active width).
  - SF = MSB of the active width.
  - PF = even parity of result[7:0].
  - Logic ops clear CF and OF.
- An index ≥ NUM_REGS in reg or r/m is illegal.

Test Plan:
1. Reset, then push {0x8900, imm 0x1234} and {0x8903, imm 0x0F00} → two results; dbg AX = 0x1234, BX = 0x0F00; status = 0x0000; out_wb = 1; first out_valid 3 cycles after acceptance.
2. Push 0x03C3 (ADD AX, BX) → out_result = 0x2134, AX = 0x2134, status = 0x0000.
3. MOV AX, 0x12FF, then push {0x0000, imm 0x0001} (byte ADD AL) → AX = 0x1200, out_result = 0x0000, status = 0x0045.
4. Push 0x3BC0 (CMP AX, AX) → out_wb = 0, AX unchanged, status = 0x0044. Push 0xFC00 (illegal opcode) → out_illegal = 1, status still 0x0044.
5. Hold out_ready = 0 and push 5 MOV entries → in_ready drops after the 4th queued entry with 1 entry in WB; out_result stable. Release out_ready → all 5 results drain in order.
6. Assert reset_n = 0 during EXEC of an ADD → no register change; out_valid = 0 and in_ready = 0 while reset is held; queue empty afterwards; dbg reads 0.

Source files
------------

// File: rtl/eu_exec_unit.sv
// Purpose: queued register/ALU execute stage for decoded 8086-style instruction words (ADD/OR/AND/SUB/XOR/CMP/MOV).
// Latency: an entry accepted at edge E0 into an idle, empty unit gives out_valid high after E3; sustained rate is 1 result per 3 cycles.
// Backpressure: in_ready = !full (low while reset is held); the result is held stable in WB until out_ready.
// Ports: clk/reset_n; in_valid/in_ready/in_instr/in_has_imm/in_imm (entry input);
//        out_valid/out_ready/out_result/out_wb/out_illegal (result output);
//        status (CF0 PF2 ZF6 SF7 OF11); dbg_sel/dbg_data (combinational register read).
module eu_exec_unit #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 in_instr,
    input  logic                        in_has_imm,
    input  logic [DATA_W-1:0]           in_imm,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic                        out_wb,
    output logic                        out_illegal,
    output logic [15:0]                 status,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int RIW = $clog2(NUM_REGS);
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    typedef struct packed {
        logic [15:0]       instr;
        logic              has_imm;
        logic [DATA_W-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR, OP_CMP, OP_MOV} op_t;

    // ---------------- input queue ----------------
    entry_t         q_mem [QUEUE_DEPTH];
    logic [QAW:0]   wr_ptr, rd_ptr;
    logic           q_empty, q_full, push, pop, ready_en;
    state_t         state;

    assign q_empty  = (wr_ptr == rd_ptr);
    assign q_full   = (wr_ptr[QAW] != rd_ptr[QAW]) && (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
    // ready_en keeps in_ready low while reset is held and for the first cycle after release
    assign in_ready = ready_en && !q_full;
    assign push     = in_valid && in_ready;
    assign pop      = !q_empty && ((state == S_IDLE) || (state == S_WB && out_ready));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr[QAW-1:0]] <= {in_instr, in_has_imm, in_imm};
    end

    // ---------------- register file and pipeline state ----------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    entry_t            cur;
    op_t               ex_op;
    logic              ex_w, ex_ill;
    logic [RIW-1:0]    ex_dst;
    logic [DATA_W-1:0] ex_src, ex_dst_val;
    logic              cf_q, pf_q, zf_q, sf_q, of_q;

    assign dbg_data = regs[dbg_sel];
    assign status   = {4'b0, of_q, 3'b0, sf_q, zf_q, 3'b0, pf_q, 1'b0, cf_q};

    // ---------------- decode of the popped entry ----------------
    logic [5:0]        opc;
    logic              dbit, wbit;
    logic [1:0]        mod;
    logic [2:0]        reg_f, rm_f;
    logic [RIW-1:0]    reg_i, rm_i, dec_dst;
    logic [DATA_W-1:0] dec_src;
    op_t               dec_op;
    logic              dec_bad_op, dec_bad_mode, dec_bad_idx;

    assign {opc, dbit, wbit, mod, reg_f, rm_f} = cur.instr;
    assign reg_i = RIW'(reg_f);
    assign rm_i  = RIW'(rm_f);

    always_comb begin
        dec_op     = OP_MOV;
        dec_bad_op = 1'b0;
        case (opc)
            6'b000000: dec_op = OP_ADD;
            6'b000010: dec_op = OP_OR;
            6'b001000: dec_op = OP_AND;
            6'b001010: dec_op = OP_SUB;
            6'b001100: dec_op = OP_XOR;
            6'b001110: dec_op = OP_CMP;
            6'b100010: dec_op = OP_MOV;
            default:   dec_bad_op = 1'b1;
        endcase
        dec_bad_idx  = (int'(reg_f) >= NUM_REGS) || (int'(rm_f) >= NUM_REGS);
        dec_dst      = rm_i;
        dec_src      = regs[reg_i];
        dec_bad_mode = 1'b0;
        if (mod == 2'b11) begin
            if (dbit) begin
                dec_dst = reg_i;
                dec_src = regs[rm_i];
            end
        end else if (mod == 2'b00 && cur.has_imm) begin
            dec_src = cur.imm;
        end else begin
            dec_bad_mode = 1'b1;
        end
    end

    // ---------------- ALU ----------------
    logic [DATA_W-1:0] a, b, res, res_m, wb_val;
    logic [DATA_W:0]   sum, diff;
    logic              a_msb, b_msb, r_msb, carry, ovf;

    always_comb begin
        a     = ex_w ? ex_src : ex_src;
        a     = ex_w ? ex_dst_val : (ex_dst_val & BYTE_MASK);
        b     = ex_w ? ex_src : (ex_src & BYTE_MASK);
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        a_msb = ex_w ? a[DATA_W-1] : a[7];
        b_msb = ex_w ? b[DATA_W-1] : b[7];
        res   = b;
        carry = 1'b0;
        case (ex_op)
            OP_ADD:          begin res = sum[DATA_W-1:0];  carry = ex_w ? sum[DATA_W]  : sum[8];  end
            OP_SUB, OP_CMP:  begin res = diff[DATA_W-1:0]; carry = ex_w ? diff[DATA_W] : diff[8]; end
            OP_OR:           res = a | b;
            OP_AND:          res = a & b;
            OP_XOR:          res = a ^ b;
            default:         res = b;
        endcase
        res_m = ex_w ? res : (res & BYTE_MASK);
        r_msb = ex_w ? res_m[DATA_W-1] : res_m[7];
        ovf   = 1'b0;
        if (ex_op == OP_ADD)
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        else if (ex_op == OP_SUB || ex_op == OP_CMP)
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        // byte writes keep the upper part of the destination
        wb_val = ex_w ? res_m : ((ex_dst_val & ~BYTE_MASK) | res_m);
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rd_ptr      <= '0;
            cur         <= '0;
            ex_op       <= OP_ADD;
            ex_w        <= 1'b0;
            ex_ill      <= 1'b0;
            ex_dst      <= '0;
            ex_src      <= '0;
            ex_dst_val  <= '0;
            cf_q        <= 1'b0;
            pf_q        <= 1'b0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_wb      <= 1'b0;
            out_illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cur    <= q_mem[rd_ptr[QAW-1:0]];
            end
            case (state)
                S_IDLE: if (!q_empty) state <= S_READ;
                S_READ: begin
                    ex_op      <= dec_op;
                    ex_w       <= wbit;
                    ex_dst     <= dec_dst;
                    ex_src     <= dec_src;
                    ex_dst_val <= regs[dec_dst];
                    ex_ill     <= dec_bad_op || dec_bad_mode || dec_bad_idx;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    out_valid   <= 1'b1;
                    out_illegal <= ex_ill;
                    if (ex_ill) begin
                        out_result <= '0;
                        out_wb     <= 1'b0;
                    end else begin
                        out_result <= res_m;
                        out_wb     <= (ex_op != OP_CMP);
                        if (ex_op != OP_CMP) regs[ex_dst] <= wb_val;
                        if (ex_op != OP_MOV) begin
                            cf_q <= carry;
                            of_q <= ovf;
                            zf_q <= (res_m == '0);
                            sf_q <= r_msb;
                            pf_q <= ~^res_m[7:0];
                        end
                    end
                    state <= S_WB;
                end
                S_WB: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= q_empty ? S_IDLE : S_READ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eu_exec_unit.sv
// Bench for eu_exec_unit: directed scenarios plus random instruction streams, checked by a
// scoreboard fed from an arithmetic reference model and drained by an independent monitor.
module tb_eu_exec_unit;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_has_imm;
    logic [15:0]   in_instr;
    logic [DW-1:0] in_imm;
    logic          out_valid, out_ready, out_wb, out_illegal;
    logic [DW-1:0] out_result;
    logic [15:0]   status;
    logic [2:0]    dbg_sel;
    logic [DW-1:0] dbg_data;

    eu_exec_unit #(.DATA_W(DW), .NUM_REGS(NR), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_has_imm(in_has_imm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wb(out_wb), .out_illegal(out_illegal), .status(status),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic          wb;
        logic          ill;
        logic [15:0]   st;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] m_regs [NR];
    bit            m_cf, m_pf, m_zf, m_sf, m_of;
    bit            rand_rdy, ready_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, got no response, expected one", name);
    endtask

    function automatic logic [15:0] m_status();
        return 16'((int'(m_of) << 11) | (int'(m_sf) << 7) | (int'(m_zf) << 6) | (int'(m_pf) << 2) | int'(m_cf));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        {m_cf, m_pf, m_zf, m_sf, m_of} = '0;
    endfunction

    // Reference: instruction semantics in plain integer arithmetic.
    function automatic exp_t model(input logic [15:0] ins, input logic hi, input logic [DW-1:0] im);
        exp_t            e;
        int              op   = int'(ins[15:10]);
        bit              d    = ins[9];
        bit              w    = ins[8];
        int              md   = int'(ins[7:6]);
        int              rg   = int'(ins[5:3]);
        int              rm   = int'(ins[2:0]);
        int              n    = w ? DW : 8;
        longint unsigned mask = (64'd1 << n) - 1;
        longint          half = longint'(64'd1 << (n - 1));
        longint unsigned a, b, r;
        longint          sa, sb, s;
        int              dst  = rm;
        bit              ill;
        logic [DW-1:0]   lowmask = 255;
        ill = !(op == 0 || op == 2 || op == 8 || op == 10 || op == 12 || op == 14 || op == 34);
        if (rg >= NR || rm >= NR) ill = 1;
        b = 0;
        if (md == 3) begin
            if (d) begin dst = rg; b = m_regs[rm]; end
            else b = m_regs[rg];
        end else if (md == 0 && hi) begin
            b = im;
        end else begin
            ill = 1;
        end
        e.ill = ill; e.wb = 0; e.res = '0;
        if (!ill) begin
            a  = m_regs[dst] & mask;
            b  = b & mask;
            sa = (a >= half) ? longint'(a) - 2 * half : longint'(a);
            sb = (b >= half) ? longint'(b) - 2 * half : longint'(b);
            r  = b;
            case (op)
                0: begin
                    r = a + b; m_cf = (r > mask); s = sa + sb;
                    m_of = (s < -half) || (s >= half); r = r & mask;
                end
                10, 14: begin
                    m_cf = (a < b); s = sa - sb;
                    m_of = (s < -half) || (s >= half); r = (a - b) & mask;
                end
                2:  begin r = a | b; m_cf = 0; m_of = 0; end
                8:  begin r = a & b; m_cf = 0; m_of = 0; end
                12: begin r = a ^ b; m_cf = 0; m_of = 0; end
                default: r = b;
            endcase
            if (op != 34) begin
                m_zf = (r == 0);
                m_sf = ((r >> (n - 1)) & 1) != 0;
                m_pf = ($countones(r & 255) % 2) == 0;
            end
            if (op != 14) begin
                e.wb = 1;
                if (w) m_regs[dst] = DW'(r);
                else   m_regs[dst] = (m_regs[dst] & ~lowmask) | DW'(r);
            end
            e.res = DW'(r);
        end
        e.st = m_status();
        return e;
    endfunction

    task automatic push(input logic [15:0] ins, input logic hi, input logic [DW-1:0] im);
        bit acc = 0;
        int n   = 0;
        in_valid = 1; in_instr = ins; in_has_imm = hi; in_imm = im;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 0;
        if (!acc) fail_now("push_accept");
        else exp_q.push_back(model(ins, hi, im));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) fail_now(name);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            dbg_sel = 3'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    // out_ready driver: either forced by the main sequence or randomised
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares each accepted result against the scoreboard and checks stall stability
    initial begin
        bit            stalled = 0;
        logic [DW-1:0] h_res;
        logic          h_wb, h_ill;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                if (stalled) begin
                    chk("stall_result", out_result, h_res);
                    chk("stall_wb", out_wb, h_wb);
                    chk("stall_illegal", out_illegal, h_ill);
                end
                if (out_ready) begin
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_result", out_result, e.res);
                        chk("out_wb", out_wb, e.wb);
                        chk("out_illegal", out_illegal, e.ill);
                        chk("status", status, e.st);
                    end
                end else begin
                    stalled = 1;
                    h_res = out_result; h_wb = out_wb; h_ill = out_illegal;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]    ops [7] = '{6'h00, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0E, 6'h22};
        logic [DW-1:0] held;
        int            cnt;
        reset_n = 0; in_valid = 0; in_instr = '0; in_has_imm = 0; in_imm = '0;
        dbg_sel = '0; rand_rdy = 0; ready_force = 1;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_wb", out_wb, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_status", status, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);
        @(posedge clk); #1;

        // 1: MOV AX/BX immediates, latency of the first result
        push(16'h8900, 1, 16'h1234);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (out_valid) break;
            cnt++;
        end
        chk("first_latency", cnt, 3);
        @(posedge clk); #1;
        push(16'h8903, 1, 16'h0F00);
        wait_drain("drain_t1");
        dbg_sel = 0; #1; chk("t1_ax", dbg_data, 16'h1234);
        dbg_sel = 3; #1; chk("t1_bx", dbg_data, 16'h0F00);
        chk("t1_status", status, 16'h0000);

        // 2: ADD AX, BX
        push(16'h03C3, 0, '0);
        wait_drain("drain_t2");
        dbg_sel = 0; #1; chk("t2_ax", dbg_data, 16'h2134);
        chk("t2_status", status, 16'h0000);

        // 3: byte ADD AL, 1 with carry out of bit 7
        push(16'h8900, 1, 16'h12FF);
        push(16'h0000, 1, 16'h0001);
        wait_drain("drain_t3");
        dbg_sel = 0; #1; chk("t3_ax", dbg_data, 16'h1200);
        chk("t3_status", status, 16'h0045);

        // 4: CMP AX, AX then an illegal opcode
        push(16'h3BC0, 0, '0);
        wait_drain("drain_t4a");
        dbg_sel = 0; #1; chk("t4_ax", dbg_data, 16'h1200);
        chk("t4_status_cmp", status, 16'h0044);
        push(16'hFC00, 0, '0);
        wait_drain("drain_t4b");
        chk("t4_status_illegal", status, 16'h0044);
        check_all_regs("t4");

        // 5: fill the queue behind a stalled result
        ready_force = 0;
        repeat (2) @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) push(16'h8900 | 16'(i), 1, 16'($urandom));
        @(negedge clk);
        chk("t5_in_ready_full", in_ready, 0);
        chk("t5_out_valid_held", out_valid, 1);
        held = out_result;
        repeat (4) @(negedge clk);
        chk("t5_result_stable", out_result, held);
        ready_force = 1;
        wait_drain("drain_t5");
        check_all_regs("t5");

        // 6: reset during EXEC of an ADD with another entry queued
        push(16'h03C3, 0, '0);
        push(16'h8901, 1, 16'h5555);
        @(posedge clk); #1;
        reset_n = 0;
        exp_q.delete();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("t6_rst_out_valid", out_valid, 0);
            chk("t6_rst_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        reset_n = 1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t6_no_output_after_reset", cnt, 0);
        check_all_regs("t6");
        chk("t6_status", status, 0);

        // random stream with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 120; i++) begin
            logic [15:0] ins;
            logic [1:0]  md;
            logic        hi;
            int          p   = $urandom_range(0, 9);
            int          sel = $urandom_range(0, 8);
            md  = (p < 5) ? 2'b11 : (p < 9) ? 2'b00 : 2'($urandom_range(1, 2));
            hi  = (md == 2'b00) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
            ins = {(sel < 7) ? ops[sel] : 6'($urandom), 1'($urandom), 1'($urandom), md, 3'($urandom), 3'($urandom)};
            push(ins, hi, DW'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        rand_rdy = 0;
        wait_drain("drain_random");
        check_all_regs("rand");
        chk("rand_status", status, m_status());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
